// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared constants and types for the ALU sequencer
// Purpose: ALU operation codes, RV32I opcodes and the sequencer state type.
// Ports: none (package).
package alu_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  localparam logic [4:0] ALU_PASS = 5'b00000;
  localparam logic [4:0] ALU_ADD  = 5'b10000;
  localparam logic [4:0] ALU_SUB  = 5'b11000;
  localparam logic [4:0] ALU_SLL  = 5'b10001;
  localparam logic [4:0] ALU_SLT  = 5'b10010;
  localparam logic [4:0] ALU_SLTU = 5'b10011;
  localparam logic [4:0] ALU_XOR  = 5'b10100;
  localparam logic [4:0] ALU_SRL  = 5'b10101;
  localparam logic [4:0] ALU_SRA  = 5'b11101;
  localparam logic [4:0] ALU_OR   = 5'b10110;
  localparam logic [4:0] ALU_AND  = 5'b10111;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD_B  = 3'd1,
    EXEC    = 3'd2,
    WB      = 3'd3,
    ILLEGAL = 3'd4
  } seq_state_t;

endpackage

// File: rtl/alu_op_decode.sv
// rtl/alu_op_decode.sv - combinational decode of RV32I OP / OP-IMM instructions
// Purpose: derive ALU op, immediate operand, legality and register fields.
// Ports:
//   i_instr   in  32  instruction word
//   o_alu_op  out 5   {1, f7b5, funct3}
//   o_is_imm  out 1   operand B comes from the immediate (OP-IMM)
//   o_legal   out 1   instruction is supported
//   o_imm     out 32  operand-B immediate (sign-extended imm or zero-extended shamt)
//   o_rs1/o_rs2/o_rd out 5 register fields
module alu_op_decode
  import alu_pkg::*;
(
  input  logic [31:0] i_instr,
  output logic [4:0]  o_alu_op,
  output logic        o_is_imm,
  output logic        o_legal,
  output logic [31:0] o_imm,
  output logic [4:0]  o_rs1,
  output logic [4:0]  o_rs2,
  output logic [4:0]  o_rd
);

  logic [6:0] w_opc;
  logic [2:0] w_f3;
  logic [6:0] w_f7;
  logic       w_f7b5;

  assign w_opc = i_instr[6:0];
  assign w_f3  = i_instr[14:12];
  assign w_f7  = i_instr[31:25];
  assign o_rd  = i_instr[11:7];
  assign o_rs1 = i_instr[19:15];
  assign o_rs2 = i_instr[24:20];

  always_comb begin
    o_legal  = 1'b0;
    o_is_imm = 1'b0;
    w_f7b5   = 1'b0;
    o_imm    = {{20{i_instr[31]}}, i_instr[31:20]};
    case (w_opc)
      OPC_OP: begin
        // The alternate funct7 only selects SUB and SRA.
        if (w_f7 == F7_BASE) begin
          o_legal = 1'b1;
        end else if (w_f7 == F7_ALT && (w_f3 == 3'b000 || w_f3 == 3'b101)) begin
          o_legal = 1'b1;
        end
        if (w_f3 == 3'b000 || w_f3 == 3'b101) begin
          w_f7b5 = i_instr[30];
        end
      end
      OPC_OP_IMM: begin
        o_is_imm = 1'b1;
        case (w_f3)
          3'b001: begin
            o_legal = (w_f7 == F7_BASE);
            o_imm   = {27'b0, i_instr[24:20]};
          end
          3'b101: begin
            o_legal = (w_f7 == F7_BASE) || (w_f7 == F7_ALT);
            o_imm   = {27'b0, i_instr[24:20]};
            w_f7b5  = i_instr[30];
          end
          default: o_legal = 1'b1;
        endcase
      end
      default: o_legal = 1'b0;
    endcase
  end

  assign o_alu_op = {1'b1, w_f7b5, w_f3};

endmodule

// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - three-step bus sequencer for the accumulator ALU
// Purpose: accept one OP / OP-IMM instruction, then run LOAD_B, EXEC, WB on the shared bus.
// Ports:
//   i_clk, i_rst (sync, active-high)
//   i_instr_valid / o_instr_ready / i_instr   instruction handshake
//   o_alu_wr, o_alu_rd, o_alu_op              ALU control
//   o_rf_rd_en, o_rf_rd_addr                  register-file read strobe
//   o_rf_wr_en, o_rf_wr_addr                  register-file write strobe
//   io_bus                                    shared 32-bit tristate bus
//   o_done, o_illegal                         one-cycle completion / reject pulses
module alu_sequencer
  import alu_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_instr_valid,
  output logic        o_instr_ready,
  input  logic [31:0] i_instr,
  output logic        o_alu_wr,
  output logic        o_alu_rd,
  output logic [4:0]  o_alu_op,
  output logic        o_rf_rd_en,
  output logic [4:0]  o_rf_rd_addr,
  output logic        o_rf_wr_en,
  output logic [4:0]  o_rf_wr_addr,
  inout  wire  [31:0] io_bus,
  output logic        o_done,
  output logic        o_illegal
);

  seq_state_t r_state;
  seq_state_t w_next;
  logic [31:0] r_instr;

  logic [31:0] w_dec_src;
  logic [4:0]  w_dec_op;
  logic        w_is_imm;
  logic        w_legal;
  logic [31:0] w_imm;
  logic [4:0]  w_rs1;
  logic [4:0]  w_rs2;
  logic [4:0]  w_rd;
  logic        w_bus_en;
  logic        w_accept;

  // In IDLE the incoming word is decoded so legality is known at the accept
  // edge; in every other state only the captured word is used.
  assign w_dec_src = (r_state == IDLE) ? i_instr : r_instr;

  alu_op_decode u_decode (
    .i_instr  (w_dec_src),
    .o_alu_op (w_dec_op),
    .o_is_imm (w_is_imm),
    .o_legal  (w_legal),
    .o_imm    (w_imm),
    .o_rs1    (w_rs1),
    .o_rs2    (w_rs2),
    .o_rd     (w_rd)
  );

  assign o_instr_ready = (r_state == IDLE);
  assign w_accept      = i_instr_valid && o_instr_ready;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_instr <= 32'd0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_instr <= i_instr;
      end
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (i_instr_valid) w_next = w_legal ? LOAD_B : ILLEGAL;
      LOAD_B:  w_next = EXEC;
      EXEC:    w_next = WB;
      WB:      w_next = IDLE;
      ILLEGAL: w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    o_alu_wr     = 1'b0;
    o_alu_rd     = 1'b0;
    o_alu_op     = ALU_PASS;
    o_rf_rd_en   = 1'b0;
    o_rf_rd_addr = 5'd0;
    o_rf_wr_en   = 1'b0;
    o_rf_wr_addr = 5'd0;
    o_done       = 1'b0;
    o_illegal    = 1'b0;
    w_bus_en     = 1'b0;
    case (r_state)
      LOAD_B: begin
        o_alu_wr = 1'b1;
        if (w_is_imm) begin
          w_bus_en = 1'b1;
        end else begin
          o_rf_rd_en   = 1'b1;
          o_rf_rd_addr = w_rs2;
        end
      end
      EXEC: begin
        o_alu_wr     = 1'b1;
        o_alu_op     = w_dec_op;
        o_rf_rd_en   = 1'b1;
        o_rf_rd_addr = w_rs1;
      end
      WB: begin
        o_alu_rd     = 1'b1;
        o_rf_wr_addr = w_rd;
        // rst is folded in so a reset landing on WB cannot commit a write.
        o_rf_wr_en   = (w_rd != 5'd0) && !i_rst;
        o_done       = 1'b1;
      end
      ILLEGAL: o_illegal = 1'b1;
      default: ;
    endcase
  end

  assign io_bus = w_bus_en ? w_imm : 32'bz;

endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - scoreboard bench for alu_sequencer with RF and ALU models on the bus
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid = 1'b0;
  logic [31:0] instr = 32'd0;
  logic        ready, alu_wr, alu_rd, rf_rd_en, rf_wr_en, done, illegal;
  logic [4:0]  alu_op, rf_rd_addr, rf_wr_addr;
  wire  [31:0] bus;

  logic [31:0] rf [32];
  logic [31:0] acc = 32'd0;
  logic        rf_load = 1'b1;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int last_acc = 0;
  int prev_acc = 0;

  typedef struct {
    logic        ill;
    logic        imm;
    logic [31:0] bval;
    logic [4:0]  baddr;
    logic [4:0]  op;
    logic [4:0]  aaddr;
    logic        wen;
    logic [4:0]  waddr;
    logic [31:0] res;
  } exp_t;

  exp_t q[$];

  alu_sequencer dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_instr_valid (valid),
    .o_instr_ready (ready),
    .i_instr       (instr),
    .o_alu_wr      (alu_wr),
    .o_alu_rd      (alu_rd),
    .o_alu_op      (alu_op),
    .o_rf_rd_en    (rf_rd_en),
    .o_rf_rd_addr  (rf_rd_addr),
    .o_rf_wr_en    (rf_wr_en),
    .o_rf_wr_addr  (rf_wr_addr),
    .io_bus        (bus),
    .o_done        (done),
    .o_illegal     (illegal)
  );

  always #5 clk = ~clk;

  assign bus = rf_rd_en ? rf[rf_rd_addr] : 32'bz;
  assign bus = alu_rd ? acc : 32'bz;

  function automatic logic [31:0] alu_f(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      5'b10000: return a + b;
      5'b11000: return a - b;
      5'b10001: return a << b[4:0];
      5'b10010: return {31'd0, $signed(a) < $signed(b)};
      5'b10011: return {31'd0, a < b};
      5'b10100: return a ^ b;
      5'b10101: return a >> b[4:0];
      5'b11101: return $unsigned($signed(a) >>> b[4:0]);
      5'b10110: return a | b;
      5'b10111: return a & b;
      default:  return b;
    endcase
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (alu_wr) acc <= (alu_op == 5'b00000) ? bus : alu_f(alu_op, bus, acc);
    if (rf_load) begin
      for (int i = 0; i < 32; i++) rf[i] <= 32'd0;
      rf[1] <= 32'd5;
      rf[2] <= 32'd3;
      rf[6] <= 32'd10;
      rf[7] <= 32'd4;
      rf[9] <= 32'h55;
    end else if (rf_wr_en && rf_wr_addr != 5'd0) begin
      rf[rf_wr_addr] <= bus;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic imm, input logic [31:0] bval, input logic [4:0] baddr,
                              input logic [4:0] op, input logic [4:0] aaddr, input logic wen,
                              input logic [4:0] waddr, input logic [31:0] res);
    exp_t e;
    e.ill = 1'b0; e.imm = imm; e.bval = bval; e.baddr = baddr; e.op = op;
    e.aaddr = aaddr; e.wen = wen; e.waddr = waddr; e.res = res;
    return e;
  endfunction

  function automatic exp_t mk_ill();
    exp_t e;
    e = mk(1'b0, 32'd0, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0);
    e.ill = 1'b1;
    return e;
  endfunction

  // Accept tracking: cyc is still the pre-edge value here, so the accept edge is cyc+1.
  always @(posedge clk) begin
    if (!rst && valid && ready) begin
      prev_acc = last_acc;
      last_acc = cyc + 1;
    end
  end

  logic        ob_en = 1'b0;
  logic [4:0]  ob_addr = 5'd0;
  logic [31:0] ob_bus = 32'd0;
  logic [4:0]  oe_op = 5'd0;
  logic [4:0]  oe_addr = 5'd0;

  always @(negedge clk) begin
    exp_t e;
    if (alu_wr && alu_op == 5'b00000) begin
      ob_en = rf_rd_en; ob_addr = rf_rd_addr; ob_bus = bus;
    end
    if (alu_wr && alu_op != 5'b00000) begin
      oe_op = alu_op; oe_addr = rf_rd_addr;
    end
    if (done || illegal) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_output done=%0b illegal=%0b", done, illegal);
      end else begin
        e = q.pop_front();
        chk("illegal", {31'd0, illegal}, {31'd0, e.ill});
        if (e.ill) begin
          chk("ill_strobes", {27'd0, alu_wr, alu_rd, rf_rd_en, rf_wr_en, done}, 32'd0);
          chk("ill_latency", cyc, last_acc);
        end else begin
          if (e.imm) begin
            chk("load_rd_en", {31'd0, ob_en}, 32'd0);
            chk("load_bus", ob_bus, e.bval);
          end else begin
            chk("load_rd_en", {31'd0, ob_en}, 32'd1);
            chk("load_addr", {27'd0, ob_addr}, {27'd0, e.baddr});
          end
          chk("exec_op", {27'd0, oe_op}, {27'd0, e.op});
          chk("exec_addr", {27'd0, oe_addr}, {27'd0, e.aaddr});
          chk("wb_wen", {31'd0, rf_wr_en}, {31'd0, e.wen});
          chk("wb_addr", {27'd0, rf_wr_addr}, {27'd0, e.waddr});
          chk("wb_result", bus, e.res);
          chk("wb_latency", cyc, last_acc + 2);
        end
      end
      ob_en = 1'b0; ob_bus = 32'hDEADBEEF; ob_addr = 5'd31; oe_op = 5'd0; oe_addr = 5'd31;
    end
  end

  // Called just after a negedge; returns on the negedge after the accept edge.
  task automatic send(input logic [31:0] ins, input bit hold);
    bit ok = 1'b0;
    instr = ins;
    valid = 1'b1;
    for (int n = 0; n < 20; n++) begin
      if (ready) begin
        @(posedge clk);
        #1;
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("accept", {31'd0, ok}, 32'd1);
    if (!hold) valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 20 && !ready; n++) @(negedge clk);
  endtask

  task automatic chk_quiet(input string name);
    chk({name, "_strobes"}, {26'd0, alu_wr, alu_rd, rf_rd_en, rf_wr_en, done, illegal}, 32'd0);
    chk({name, "_ready"}, {31'd0, ready}, 32'd1);
    chk({name, "_addr"}, {17'd0, alu_op, rf_rd_addr, rf_wr_addr}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rf_load = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk_quiet("reset");

    q.push_back(mk(1'b0, 32'd0, 5'd2, 5'b10000, 5'd1, 1'b1, 5'd3, 32'd8));
    send(32'h002081B3, 1'b0);
    q.push_back(mk(1'b0, 32'd0, 5'd7, 5'b11000, 5'd6, 1'b1, 5'd5, 32'd6));
    send(32'h407302B3, 1'b0);
    q.push_back(mk(1'b0, 32'd0, 5'd7, 5'b11101, 5'd6, 1'b1, 5'd8, 32'd0));
    send(32'h40735433, 1'b0);
    q.push_back(mk(1'b0, 32'd0, 5'd2, 5'b10000, 5'd1, 1'b0, 5'd0, 32'd8));
    send(32'h00208033, 1'b0);
    q.push_back(mk(1'b1, 32'hFFFFFFFF, 5'd0, 5'b10000, 5'd0, 1'b1, 5'd1, 32'hFFFFFFFF));
    send(32'hFFF00093, 1'b0);
    q.push_back(mk(1'b1, 32'h00000004, 5'd0, 5'b11101, 5'd2, 1'b1, 5'd2, 32'd0));
    send(32'h40415113, 1'b0);
    q.push_back(mk_ill());
    send(32'h40411113, 1'b0);
    q.push_back(mk_ill());
    send(32'h00000003, 1'b0);
    chk("ill_pulse", {30'd0, illegal, ready}, 32'b10);
    @(negedge clk);
    chk("ill_recover", {30'd0, illegal, ready}, 32'b01);

    // Back-to-back: valid stays high, the second word must wait out the first.
    q.push_back(mk(1'b0, 32'd0, 5'd7, 5'b10100, 5'd6, 1'b1, 5'd10, 32'd14));
    q.push_back(mk(1'b0, 32'd0, 5'd7, 5'b10110, 5'd6, 1'b1, 5'd11, 32'd14));
    send(32'h00734533, 1'b1);
    send(32'h007365B3, 1'b0);
    chk("b2b_gap", last_acc - prev_acc, 32'd4);

    // Reset while in EXEC: no completion, x9 untouched.
    wait_idle();
    send(32'h007304B3, 1'b0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    chk_quiet("rst_exec");
    repeat (5) @(negedge clk);
    chk("rst_exec_x9", rf[9], 32'h55);

    // Reset coinciding with WB: done still pulses but no RF write.
    q.push_back(mk(1'b0, 32'd0, 5'd7, 5'b10000, 5'd6, 1'b0, 5'd9, 32'd14));
    send(32'h007304B3, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    chk_quiet("rst_wb");
    repeat (3) @(negedge clk);
    chk("rst_wb_x9", rf[9], 32'h55);

    repeat (6) @(negedge clk);
    chk("queue_empty", q.size(), 32'd0);
    chk("rf_x3", rf[3], 32'd8);
    chk("rf_x5", rf[5], 32'd6);
    chk("rf_x8", rf[8], 32'd0);
    chk("rf_x0", rf[0], 32'd0);
    chk("rf_x1", rf[1], 32'hFFFFFFFF);
    chk("rf_x2", rf[2], 32'd0);
    chk("rf_x10", rf[10], 32'd14);
    chk("rf_x11", rf[11], 32'd14);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
